pe_accum_ctrl: RTL and testbench
================================

// Module: pe_accum_ctrl
// PURPOSE
//  Accumulator and control stage that sits directly downstream of the PE's N-bit add/sub adder.
//  The adder is instantiated externally, and this block closes the loop around it:
//   - drives the adder's A input with the running sum, and its B and k inputs with the incoming term and sub flag;
//   - registers the adder's N-bit sum back into the running sum;
//   - counts accepted terms and flags signed overflow;
//   - presents the finished dot-product result through a valid/ready handshake.
// PARAMETERS
//  N   8   data width of terms, sum and result (two's complement)
//  K   4   terms per dot product (K >= 1)
//  CW  3   count width, equal to clog2(K+1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   begin a new dot product (clears the running sum)
//  in_valid   in   1   term_in/term_sub are valid this cycle
//  in_ready   out  1   block accepts a term this cycle
//  term_in    in   N   signed term
//  term_sub   in   1   1 = subtract term, 0 = add term
//  add_a      out  N   to adder A; equals acc_q
//  add_b      out  N   to adder B; equals term_in
//  add_k      out  1   to adder k; equals term_sub
//  sum_in     in   N   adder result, truncated to N bits
//  out_valid  out  1   result is valid
//  out_ready  in   1   consumer takes the result
//  result     out  N   final accumulated value (equals acc_q)
//  ovf        out  1   sticky signed overflow for the current dot product
//  busy       out  1   state is not IDLE
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately):
//   - state goes to IDLE;
//   - acc_q, cnt, ovf, in_ready, out_valid and busy all go to 0.
//  States: IDLE, ACCUM, DONE (2-bit encoding).
//  IDLE:
//   - start=1: acc_q<=0, cnt<=0, ovf<=0, go to ACCUM.
//   - in_valid is ignored.
//  ACCUM:
//   - in_ready=1.
//   - Accept when in_valid=1: acc_q<=sum_in, cnt<=cnt+1, ovf<=ovf|ov.
//   - cnt==K-1 on an accepted term: go to DONE.
//   - in_valid=0: hold all state; stall cycles are not counted.
//   - start=1 restarts (clears as in IDLE) and overrides any in_valid in the same cycle.
//  DONE:
//   - out_valid=1, in_ready=0, terms are ignored.
//   - result and ovf stay stable until out_ready=1.
//   - out_ready=1: go to IDLE; if start=1 in the same cycle, go straight to ACCUM with acc cleared.
//   - start=1 with out_ready=0 is ignored (the result must not be lost).
//  Overflow rule for each accepted term:
//   - eff = term_sub ? ~term_in[N-1] : term_in[N-1]
//   - ov = (acc_q[N-1]==eff) && (sum_in[N-1]!=acc_q[N-1])
//   - This covers subtracting the most negative value: 0 - (-2^(N-1)) raises ov.
//  Arithmetic wraps modulo 2^N. The result is not saturated.
//  add_a, add_b and add_k are purely combinational; there is no register between this block and the adder.
//  Latency: out_valid rises in the cycle after the K-th accepted term; minimum start-to-out_valid is K+1 cycles.
//  All outputs except add_* are registered or decoded from the state register only.
// STRUCTURE
//  Shared package:
//   - state localparams (S_IDLE=0, S_ACCUM=1, S_DONE=2);
//   - default N and K;
//   - function add_ovf(a_msb, b_msb, sub, s_msb) implementing the overflow rule.
//  Single module with no sub-modules. The adder lives in the parent PE, so this block stays arithmetic-free.
// TESTING
//  Test configuration is N=8, K=4, and the bench models the adder.
//  1. start; terms +3, +5, sub 2, +7, no gaps -> out_valid at cycle 5; result=13 (0x0D); ovf=0.
//  2. start; terms +100, +100, +0, +0 -> result=0xC8 (-56); ovf=1 and stays 1 until the next start.
//  3. start; sub -128 as the first term -> ovf=1.
//     Separate run: acc=-1, then sub -128 -> sum=127; ovf stays 0.
//  4. Gaps:
//     - terms with in_valid gaps of 0, 2 and 1 cycles -> cnt advances only on accepted terms; out_valid after the 4th.
//     - hold out_ready=0 for 3 cycles -> out_valid and result stable, in_ready=0, extra terms ignored.
//  5. Assert rst for 1 cycle after 2 terms -> all outputs 0 in IDLE; a new start then gives the correct sum.
//  6. Handshake edge cases:
//     - in DONE, assert start and out_ready in the same cycle -> ACCUM, acc=0, next result correct.
//     - start alone with out_ready=0 -> stays in DONE.

Source files
------------

// File: rtl/pe_accum_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pe_accum_ctrl_pkg
//   Shared definitions for the PE accumulator/control stage.
//   Contents:
//     state_e   - controller state encoding (IDLE, ACCUM, DONE)
//     DEF_N     - default data width of terms, sum and result
//     DEF_K     - default number of terms per dot product
//     add_ovf() - signed overflow detect for one add/sub step of the
//                 external adder, using only the sign bits
// ---------------------------------------------------------------------------
package pe_accum_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int DEF_N = 8;
    localparam int DEF_K = 4;

    // A subtract is an add of the negated operand, so the operand sign
    // that matters is the flipped one. Overflow happens when both
    // effective operands share a sign and the sum's sign differs from it.
    // Subtracting the most negative value is caught too, because its
    // effective sign is positive.
    function automatic logic add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic sub,
        input logic s_msb
    );
        logic eff;
        eff = sub ? ~b_msb : b_msb;
        return (a_msb == eff) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pe_accum_ctrl.sv
// ---------------------------------------------------------------------------
// pe_accum_ctrl
//   Accumulator and control stage wrapped around the PE's external N-bit
//   add/sub adder. The running sum feeds adder A. The incoming term and the
//   subtract flag feed adder B and k. The adder output is registered back as
//   the new running sum. After K accepted terms, the result is held behind a
//   valid/ready handshake.
//
//   Ports:
//     clk_i        rising-edge clock
//     rst_i        asynchronous active-high reset
//     start_i      begin a new dot product (clears sum, count, overflow)
//     in_valid_i   term_in_i/term_sub_i valid this cycle
//     in_ready_o   block accepts a term this cycle (state ACCUM)
//     term_in_i    signed N-bit term
//     term_sub_i   1 = subtract term, 0 = add term
//     add_a_o      adder A operand (running sum)
//     add_b_o      adder B operand (term_in_i)
//     add_k_o      adder subtract control (term_sub_i)
//     sum_in_i     adder result, N bits, wrapped
//     out_valid_o  result valid (state DONE)
//     out_ready_i  consumer takes the result
//     result_o     accumulated value
//     ovf_o        sticky signed overflow for the current dot product
//     busy_o       controller is not IDLE
// ---------------------------------------------------------------------------
module pe_accum_ctrl
    import pe_accum_ctrl_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int K  = DEF_K,
    parameter int CW = $clog2(K + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] term_in_i,
    input  logic         term_sub_i,
    output logic [N-1:0] add_a_o,
    output logic [N-1:0] add_b_o,
    output logic         add_k_o,
    input  logic [N-1:0] sum_in_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] result_o,
    output logic         ovf_o,
    output logic         busy_o
);

    state_e         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           term_ov;

    // Adder operands are driven straight through. The adder sits in the
    // parent PE, so this block does no arithmetic of its own on the data.
    assign add_a_o = acc_q;
    assign add_b_o = term_in_i;
    assign add_k_o = term_sub_i;

    assign term_ov = add_ovf(acc_q[N-1], term_in_i[N-1], term_sub_i, sum_in_i[N-1]);

    // Next-state logic. In ACCUM, start has priority over a term that
    // arrives in the same cycle. In DONE, start is only honoured together
    // with out_ready, so an untaken result is never dropped.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_ACCUM: begin
                if (start_i) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (in_valid_i) begin
                    acc_d = sum_in_i;
                    cnt_d = cnt_q + CW'(1);
                    ovf_d = ovf_q | term_ov;
                    if (cnt_q == CW'(K - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    if (start_i) begin
                        state_d = S_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake and status flags are decoded from the state register only,
    // so they stay glitch-free and never depend on the inputs.
    assign in_ready_o  = (state_q == S_ACCUM);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = acc_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_accum_ctrl
//   Bench for pe_accum_ctrl with N=8, K=4. The bench plays the part of the
//   external adder. A behavioural model tracks the dot product as a plain
//   signed integer, and every falling edge compares all outputs to it.
//   Directed scenarios add literal expectations, and a random phase follows.
// ---------------------------------------------------------------------------
module tb_pe_accum_ctrl;

    localparam int N = 8;
    localparam int K = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [N-1:0] termIn = '0;
    logic         termSub = 1'b0;
    logic [N-1:0] addA, addB;
    logic         addK;
    logic [N-1:0] sumIn;
    logic         outValid;
    logic         outReady = 1'b0;
    logic [N-1:0] result;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;

    always #5 clk = ~clk;

    // The external adder, as the parent PE would provide it.
    assign sumIn = addK ? (addA - addB) : (addA + addB);

    pe_accum_ctrl #(.N(N), .K(K), .CW(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .in_valid_i (inValid),
        .in_ready_o (inReady),
        .term_in_i  (termIn),
        .term_sub_i (termSub),
        .add_a_o    (addA),
        .add_b_o    (addB),
        .add_k_o    (addK),
        .sum_in_i   (sumIn),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .result_o   (result),
        .ovf_o      (ovf),
        .busy_o     (busy)
    );

    // Behavioural model: a phase name, the true signed sum wrapped to 8 bits,
    // the number of terms taken, and a sticky flag.
    localparam int PH_IDLE = 0, PH_ACCUM = 1, PH_DONE = 2;
    int mPhase = PH_IDLE;
    int mAcc = 0;
    int mTaken = 0;
    bit mOvf = 1'b0;

    function automatic int wrap8(input int v);
        logic [7:0] b;
        b = v[7:0];
        return int'($signed(b));
    endfunction

    // The model clears its sum, count and flag at the start of each dot product.
    always @(posedge clk or posedge rst) begin
        int t, full;
        if (rst) begin
            mPhase = PH_IDLE; mAcc = 0; mTaken = 0; mOvf = 1'b0;
        end else begin
            case (mPhase)
                PH_IDLE: if (start) begin
                    mPhase = PH_ACCUM; mAcc = 0; mTaken = 0; mOvf = 1'b0;
                end
                PH_ACCUM: begin
                    if (start) begin
                        mAcc = 0; mTaken = 0; mOvf = 1'b0;
                    end else if (inValid) begin
                        t = int'($signed(termIn));
                        full = termSub ? (mAcc - t) : (mAcc + t);
                        if (full > 127 || full < -128) mOvf = 1'b1;
                        mAcc = wrap8(full);
                        mTaken++;
                        if (mTaken == K) mPhase = PH_DONE;
                    end
                end
                default: if (outReady) begin
                    if (start) begin
                        mPhase = PH_ACCUM; mAcc = 0; mTaken = 0; mOvf = 1'b0;
                    end else begin
                        mPhase = PH_IDLE;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        logic [7:0] expAcc;
        expAcc = mAcc[7:0];
        checkOutput("m_in_ready", 32'(inReady), 32'(mPhase == PH_ACCUM));
        checkOutput("m_out_valid", 32'(outValid), 32'(mPhase == PH_DONE));
        checkOutput("m_busy", 32'(busy), 32'(mPhase != PH_IDLE));
        checkOutput("m_result", 32'(result), 32'(expAcc));
        checkOutput("m_ovf", 32'(ovf), 32'(mOvf));
        checkOutput("m_add_a", 32'(addA), 32'(expAcc));
        checkOutput("m_add_b", 32'(addB), 32'(termIn));
        checkOutput("m_add_k", 32'(addK), 32'(termSub));
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [7:0] t,
                                 input logic sub, input logic r);
        start = s; inValid = v; termIn = t; termSub = sub; outReady = r;
        stepCycle();
        start = 1'b0; inValid = 1'b0; outReady = 1'b0;
    endtask

    task automatic sendTerm(input logic [7:0] t, input logic sub, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            applyStimulus(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b0);
        end
        applyStimulus(1'b0, 1'b1, t, sub, 1'b0);
    endtask

    task automatic waitDone();
        int n = 0;
        while (!outValid && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("wait_out_valid", 32'(outValid), 32'd1);
    endtask

    task automatic takeResult();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int startMark;
        logic [7:0] held;
        #1 rst = 1'b1;
        stepCycle();
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        rst = 1'b0;
        stepCycle();

        // Test 1: +3 +5 -2 +7 -> 13
        startMark = cycleCount;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        sendTerm(8'd3, 1'b0, 0);
        sendTerm(8'd5, 1'b0, 0);
        sendTerm(8'd2, 1'b1, 0);
        sendTerm(8'd7, 1'b0, 0);
        waitDone();
        checkOutput("t1_latency", 32'(cycleCount - startMark), 32'd5);
        checkOutput("t1_result", 32'(result), 32'h0D);
        checkOutput("t1_ovf", 32'(ovf), 32'd0);
        takeResult();

        // Test 2: 100 + 100 overflows to -56, and the flag is sticky
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        sendTerm(8'd100, 1'b0, 0);
        sendTerm(8'd100, 1'b0, 0);
        checkOutput("t2_ovf_early", 32'(ovf), 32'd1);
        sendTerm(8'd0, 1'b0, 0);
        sendTerm(8'd0, 1'b0, 0);
        waitDone();
        checkOutput("t2_result", 32'(result), 32'hC8);
        checkOutput("t2_ovf", 32'(ovf), 32'd1);
        takeResult();
        checkOutput("t2_ovf_idle", 32'(ovf), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t2_ovf_cleared", 32'(ovf), 32'd0);

        // Test 3: 0 - (-128) overflows; -1 - (-128) = 127 does not
        sendTerm(8'h80, 1'b1, 0);
        checkOutput("t3_ovf_neg_min", 32'(ovf), 32'd1);
        for (int i = 0; i < 3; i++) sendTerm(8'h00, 1'b0, 0);
        takeResult();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        sendTerm(8'hFF, 1'b0, 0);
        sendTerm(8'h80, 1'b1, 0);
        checkOutput("t3_sum127", 32'(result), 32'h7F);
        checkOutput("t3_no_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 2; i++) sendTerm(8'h00, 1'b0, 0);
        takeResult();

        // Test 4: gaps of 0/2/1 cycles, then a held-off result
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        sendTerm(8'd10, 1'b0, 0);
        sendTerm(8'd20, 1'b0, 2);
        sendTerm(8'd5, 1'b1, 1);
        checkOutput("t4_not_done", 32'(outValid), 32'd0);
        sendTerm(8'd1, 1'b0, 0);
        checkOutput("t4_done", 32'(outValid), 32'd1);
        held = result;
        checkOutput("t4_result", 32'(held), 32'h1A);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'b0);
            checkOutput("t4_hold_valid", 32'(outValid), 32'd1);
            checkOutput("t4_hold_ready", 32'(inReady), 32'd0);
            checkOutput("t4_hold_result", 32'(result), 32'h1A);
        end
        takeResult();

        // Test 5: reset mid-accumulation, then a clean run
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        sendTerm(8'd7, 1'b0, 0);
        sendTerm(8'd8, 1'b0, 0);
        rst = 1'b1;
        #1;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_in_ready", 32'(inReady), 32'd0);
        checkOutput("t5_result", 32'(result), 32'd0);
        stepCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendTerm(8'd1, 1'b0, 0);
        checkOutput("t5_new_sum", 32'(result), 32'd4);

        // Test 6: start with out_ready restarts; start alone is ignored in DONE
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t6_restart_ready", 32'(inReady), 32'd1);
        checkOutput("t6_restart_acc", 32'(result), 32'd0);
        for (int i = 1; i <= 4; i++) sendTerm(8'(i), 1'b0, 0);
        checkOutput("t6_result", 32'(result), 32'd10);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t6_still_done", 32'(outValid), 32'd1);
        checkOutput("t6_kept_result", 32'(result), 32'd10);
        takeResult();

        // Random phase: every output is checked against the model each cycle
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 11) == 0, 1'($urandom),
                          8'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
        end
        rst = 1'b0;
        stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
